seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, registered successor to the core combinational ALU for the RV32 datapath.
- Executes single-cycle integer ops and iterative MUL/MULHU/DIVU/REMU behind a valid/ready handshake.
- Sits between the decode/operand stage and writeback; it stalls the pipeline through in_ready/out_valid.
- Provides an equality flag for branch resolution.

Parameters:
- WIDTH, 32: operand/result width in bits; power of two, minimum 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from in2; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of any in-flight op
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept an op
- op  input  4  operation select (encoding below)
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out_valid  output  1  result/zero valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  registered (in1 == in2) of the accepted op
- busy  output  1  iterative op in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0: state=IDLE, result=0, zero=0, out_valid=0, busy=0, in_ready=1.
- Op encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 SUB
  - 1000 SLT (signed), 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned)
  - 1100 DIVU, 1101 REMU, 1110/1111 reserved (result=0, 1-cycle)
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Shifts use in2[SHW-1:0] only. SLT/SLTU produce 0 or 1, zero-extended.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Accept = in_valid && in_ready; in1, in2, op and zero=(in1==in2) are captured at accept.
- IDLE, accept of a 1-cycle op (0000-1001, 1110, 1111): result is registered; next state DONE. Latency 1 cycle.
- IDLE, accept of an iterative op: next state BUSY; busy=1; counter loads WIDTH-1.
  - MUL/MULHU: shift-add over a 2*WIDTH-bit product register, one multiplier bit per cycle.
  - DIVU/REMU: restoring division, one quotient bit per cycle.
  - Total WIDTH cycles in BUSY, then DONE. Latency from accept to out_valid is WIDTH+1 cycles.
- Divide by zero (in2=0): DIVU result = all ones; REMU result = in1. Latency is unchanged (no early exit); no exception.
- DONE: out_valid=1. result and zero are held stable until out_ready=1, then next state IDLE. No new accept in the same cycle (single outstanding op; throughput is at most one op per 2 cycles).
- out_ready is ignored when out_valid=0.
- flush=1 in any state: next state IDLE, out_valid=0, busy=0; result keeps its last value. flush has priority over accept and out_ready in the same cycle.
- Inputs are don't-care while not accepted; internal registers change only on accept or while BUSY.
- Mid-operation asynchronous reset: immediate return to the reset values, with no partial result visible.

Decomposition:
- Shared package alu_pkg:
  - op encoding localparams (ALU_AND ... ALU_REMU)
  - state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - reserved-op default result
  - the same package is used by the decoder.
- Natural sub-module seq_muldiv_core: owns the iteration counter, the product/remainder registers and the shift-add/restoring-divide step. It has start/done strobes and is parametrised by WIDTH. The top level holds the FSM, the handshake and the single-cycle op mux.

Test Plan:
- Single-cycle ops, WIDTH=32:
  - in1=3, in2=2, ADD -> result 5; XOR -> 1; SLL -> 12; SUB -> 1.
  - SLT with in1=0xFFFFFFFF, in2=1 -> 1; SLTU with the same operands -> 0.
  - out_valid exactly 1 cycle after accept.
- Zero flag: in1=in2=7, AND -> zero=1; in1=1, in2=0 -> zero=0. Both held through DONE.
- Iterative:
  - MUL 0x10000 * 0x10000 -> result 0; MULHU -> 1; out_valid 33 cycles after accept; in_ready=0 throughout.
  - DIVU 100/7 -> 14; REMU -> 2.
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/out_valid stable and in_ready=0; the block returns to IDLE the cycle after out_ready=1.
- Abort: flush asserted on BUSY cycle 10 of a DIVU -> IDLE next cycle, no out_valid; the following ADD 1+1 -> 2.
- Async reset: deassert rst_n mid-MUL -> out_valid=0, busy=0, result=0 immediately (no clock edge needed); a clean op succeeds after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op and state encodings shared by seq_alu and the decoder.
//   ALU_* : 4-bit op select values
//   state_t : handshake FSM states
//   RSVD_FILL : fill bit for the result of reserved ops
//   is_iter() : true for the multi-cycle MUL/MULHU/DIVU/REMU group
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_SUB   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    // Reserved ops (1110/1111) return a result filled with this bit.
    localparam logic RSVD_FILL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) ||
               (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// seq_muldiv_core: bit-serial unsigned multiply / restoring divide.
//   i_start  : load operands and begin WIDTH iterations
//   i_is_div : 1 = divide, 0 = multiply (latched at start)
//   i_flush  : abandon the current iteration sequence
//   o_done   : high during the last iteration cycle
//   o_lo/o_hi: post-step accumulator halves, valid with o_done
//              (mul: product low/high, div: quotient/remainder)
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_div;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;

    always_comb begin
        // Multiply: add B into the upper half when the current multiplier
        // bit is set, then shift right; the carry lands in the top bit.
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        // Divide: remainder shifted left with the next dividend bit.
        w_rem  = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff = w_rem - {1'b0, r_b};
        if (r_div) begin
            if (w_rem >= {1'b0, r_b})
                w_acc_nx = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
                w_acc_nx = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    assign o_done = r_busy && (r_cnt == '0);
    assign o_lo   = w_acc_nx[WIDTH-1:0];
    assign o_hi   = w_acc_nx[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= 1'b0;
            r_cnt  <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_div  <= i_is_div;
            r_cnt  <= CW'(WIDTH - 1);
            r_b    <= i_b;
            r_acc  <= {{WIDTH{1'b0}}, i_a};
        end else if (r_busy) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0)
                r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered RV32 ALU with iterative MUL/MULHU/DIVU/REMU.
//   in_valid/in_ready  : op + operand handshake (accept only in IDLE)
//   out_valid/out_ready: result handshake, result/zero held in DONE
//   flush              : synchronous abort back to IDLE
//   result, zero       : registered result and (in1 == in2) of accepted op
//   busy               : iterative op in progress
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] w_single;
    logic             w_accept;
    logic             w_iter;
    logic             w_core_done;
    logic [WIDTH-1:0] w_core_lo;
    logic [WIDTH-1:0] w_core_hi;

    // flush outranks accept, so a flushed cycle never starts an op.
    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_iter   = is_iter(op);

    always_comb begin
        w_single = {WIDTH{RSVD_FILL}};
        case (op)
            ALU_AND:  w_single = in1 & in2;
            ALU_OR:   w_single = in1 | in2;
            ALU_ADD:  w_single = in1 + in2;
            ALU_XOR:  w_single = in1 ^ in2;
            ALU_SLL:  w_single = in1 << in2[SHW-1:0];
            ALU_SRL:  w_single = in1 >> in2[SHW-1:0];
            ALU_SRA:  w_single = WIDTH'($signed(in1) >>> in2[SHW-1:0]);
            ALU_SUB:  w_single = in1 - in2;
            ALU_SLT:  w_single = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            ALU_SLTU: w_single = {{(WIDTH-1){1'b0}}, in1 < in2};
            default:  w_single = {WIDTH{RSVD_FILL}};
        endcase
    end

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (flush),
        .i_start  (w_accept && w_iter),
        .i_is_div ((op == ALU_DIVU) || (op == ALU_REMU)),
        .i_a      (in1),
        .i_b      (in2),
        .o_done   (w_core_done),
        .o_lo     (w_core_lo),
        .o_hi     (w_core_hi)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nx = w_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_core_done) w_state_nx = ST_DONE;
            ST_DONE: if (out_ready) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
        if (flush)
            w_state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= ALU_AND;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_accept) begin
                r_op   <= op;
                r_zero <= (in1 == in2);
                if (!w_iter)
                    r_result <= w_single;
            end else if (!flush && (r_state == ST_BUSY) && w_core_done) begin
                // MUL and DIVU take the low half (product low / quotient).
                r_result <= ((r_op == ALU_MUL) || (r_op == ALU_DIVU)) ? w_core_lo : w_core_hi;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_BUSY);
    assign result    = r_result;
    assign zero      = r_zero;

endmodule
